// File: rtl/heat_cmd_pkg.sv
// Shared definitions for the heat-solver command sequencer.
//   cmd_mode_e : solver bus command modes (drives solver ui_in[7:6])
//   ADDR_*     : solver configuration register addresses
//   state_e    : sequencer FSM states
package heat_cmd_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_NOP  = 2'b01,
    MODE_READ = 2'b10,
    MODE_CFG  = 2'b11
  } cmd_mode_e;

  localparam logic [5:0] ADDR_ALPHA  = 6'b000000;
  localparam logic [5:0] ADDR_SOURCE = 6'b000101;
  localparam logic [5:0] ADDR_INIT   = 6'b000111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_ALPHA,
    S_CFG_SRC,
    S_CFG_INIT,
    S_RUN,
    S_READ,
    S_HOLD
  } state_e;

endpackage

// File: rtl/heat_cmd_sequencer.sv
// Heat-solver command sequencer. On start it configures the solver (alpha,
// heat source, initial pattern), issues iter_count*CELLS RUN cycles, reads the
// max-temperature cell index back and offers it on a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin a job (IDLE only) / cancel a running job
//   alpha_cfg, src_en,
//   init_pat, iter_count  job parameters, latched on start
//   cmd_mode/addr/data    solver command bus (ui_in[7:6], ui_in[5:0], uio_in)
//   resp                  solver response (uo_out); [5:0] holds the cell index
//   busy                  job in progress
//   result, result_valid,
//   result_ready          result handshake
module heat_cmd_sequencer
  import heat_cmd_pkg::*;
#(
  parameter int unsigned CELLS    = 64,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        alpha_cfg,
  input  logic              src_en,
  input  logic [7:0]        init_pat,
  input  logic [ITER_W-1:0] iter_count,
  output logic [1:0]        cmd_mode,
  output logic [5:0]        cmd_addr,
  output logic [7:0]        cmd_data,
  input  logic [7:0]        resp,
  output logic              busy,
  output logic [5:0]        result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int unsigned RUN_W = ITER_W + $clog2(CELLS);
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

  state_e            state_q;
  cmd_mode_e         cmd_mode_q;
  logic [5:0]        cmd_addr_q;
  logic [7:0]        cmd_data_q;
  logic              busy_q;
  logic [5:0]        result_q;
  logic              result_valid_q;
  logic [RUN_W-1:0]  run_cnt_q;
  logic [LAT_W-1:0]  rd_cnt_q;
  logic [7:0]        alpha_q;
  logic              src_q;
  logic [7:0]        pat_q;
  logic [ITER_W-1:0] iter_q;

  // Only the cell index bits of the response are meaningful.
  logic unused_resp_hi;
  assign unused_resp_hi = ^resp[7:6];

  // Outputs are registered alongside the state they belong to, so every bus
  // value is loaded on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_mode_q     <= MODE_NOP;
      cmd_addr_q     <= '0;
      cmd_data_q     <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      run_cnt_q      <= '0;
      rd_cnt_q       <= '0;
      alpha_q        <= '0;
      src_q          <= 1'b0;
      pat_q          <= '0;
      iter_q         <= '0;
    end else if (abort && state_q != S_IDLE) begin
      // Abort beats everything, including a capture on the final READ edge.
      state_q        <= S_IDLE;
      cmd_mode_q     <= MODE_NOP;
      cmd_addr_q     <= '0;
      cmd_data_q     <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      run_cnt_q      <= '0;
      rd_cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            alpha_q    <= alpha_cfg;
            src_q      <= src_en;
            pat_q      <= init_pat;
            iter_q     <= iter_count;
            busy_q     <= 1'b1;
            state_q    <= S_CFG_ALPHA;
            cmd_mode_q <= MODE_CFG;
            cmd_addr_q <= ADDR_ALPHA;
            cmd_data_q <= alpha_cfg;
          end
        end
        S_CFG_ALPHA: begin
          state_q    <= S_CFG_SRC;
          cmd_mode_q <= MODE_CFG;
          cmd_addr_q <= ADDR_SOURCE;
          cmd_data_q <= {7'b0, src_q};
        end
        S_CFG_SRC: begin
          state_q    <= S_CFG_INIT;
          cmd_mode_q <= MODE_CFG;
          cmd_addr_q <= ADDR_INIT;
          cmd_data_q <= pat_q;
        end
        S_CFG_INIT: begin
          cmd_addr_q <= '0;
          cmd_data_q <= '0;
          if (iter_q != '0) begin
            state_q    <= S_RUN;
            cmd_mode_q <= MODE_RUN;
            run_cnt_q  <= RUN_W'(iter_q) * RUN_W'(CELLS);
          end else begin
            state_q    <= S_READ;
            cmd_mode_q <= MODE_READ;
            rd_cnt_q   <= LAT_W'(READ_LAT);
          end
        end
        S_RUN: begin
          if (run_cnt_q == RUN_W'(1)) begin
            state_q    <= S_READ;
            cmd_mode_q <= MODE_READ;
            run_cnt_q  <= '0;
            rd_cnt_q   <= LAT_W'(READ_LAT);
          end else begin
            run_cnt_q <= run_cnt_q - RUN_W'(1);
          end
        end
        S_READ: begin
          if (rd_cnt_q <= LAT_W'(1)) begin
            result_q       <= resp[5:0];
            result_valid_q <= 1'b1;
            state_q        <= S_HOLD;
            cmd_mode_q     <= MODE_NOP;
            rd_cnt_q       <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q - LAT_W'(1);
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cmd_mode_q <= MODE_NOP;
          cmd_addr_q <= '0;
          cmd_data_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_mode     = cmd_mode_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_data     = cmd_data_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_heat_cmd_sequencer.sv
// Self-checking bench for heat_cmd_sequencer. Each job's expected bus trace is
// built from the command rules as a queue and compared cycle by cycle; the
// solver model answers READ with a chosen response byte.
module tb_heat_cmd_sequencer;

  localparam int unsigned CELLS    = 64;
  localparam int unsigned ITER_W   = 8;
  localparam int unsigned READ_LAT = 2;

  localparam logic [15:0] BUS_NOP = {2'b01, 6'd0, 8'd0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        alpha_cfg = '0;
  logic              src_en = 1'b0;
  logic [7:0]        init_pat = '0;
  logic [ITER_W-1:0] iter_count = '0;
  logic [1:0]        cmd_mode;
  logic [5:0]        cmd_addr;
  logic [7:0]        cmd_data;
  logic [7:0]        resp;
  logic              busy;
  logic [5:0]        result;
  logic              result_valid;
  logic              result_ready = 1'b0;

  logic [7:0]        resp_val = '0;
  logic [5:0]        exp_result = '0;
  int                n_checks = 0;
  int                n_errors = 0;

  always #5 clk = ~clk;

  // Solver model: returns the job's answer only while READ is on the bus.
  assign resp = (cmd_mode == 2'b10) ? resp_val : 8'hC3;

  heat_cmd_sequencer #(
    .CELLS   (CELLS),
    .ITER_W  (ITER_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .alpha_cfg   (alpha_cfg),
    .src_en      (src_en),
    .init_pat    (init_pat),
    .iter_count  (iter_count),
    .cmd_mode    (cmd_mode),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .resp        (resp),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".bus"},   32'({cmd_mode, cmd_addr, cmd_data}), 32'(BUS_NOP));
    check_eq({tag, ".busy"},  32'(busy), 32'(0));
    check_eq({tag, ".valid"}, 32'(result_valid), 32'(0));
    check_eq({tag, ".result"}, 32'(result), 32'(exp_result));
  endtask

  task automatic scramble_inputs();
    alpha_cfg  = 8'($urandom);
    src_en     = 1'($urandom);
    init_pat   = 8'($urandom);
    iter_count = ITER_W'($urandom);
  endtask

  // abort_at / glitch_at: trace index after which abort / a stray start is
  // driven (-1 = never). hold_abort: assert abort alongside ready in HOLD.
  task automatic run_job(input logic [7:0] a, input logic s, input logic [7:0] p,
                         input int unsigned it, input logic [7:0] rv,
                         input int unsigned rdy_delay, input int abort_at,
                         input int glitch_at, input bit rst_at_read,
                         input bit hold_abort, input bit hold_ready);
    logic [15:0] trace[$];
    int          first_read;
    trace.push_back({2'b11, 6'd0, a});
    trace.push_back({2'b11, 6'd5, 7'b0, s});
    trace.push_back({2'b11, 6'd7, p});
    for (int unsigned k = 0; k < it * CELLS; k++) trace.push_back({2'b00, 6'd0, 8'd0});
    for (int unsigned k = 0; k < READ_LAT; k++) trace.push_back({2'b10, 6'd0, 8'd0});
    first_read = 3 + int'(it * CELLS);

    resp_val   = rv;
    alpha_cfg  = a;
    src_en     = s;
    init_pat   = p;
    iter_count = ITER_W'(it);
    start      = 1'b1;
    step();
    start = 1'b0;
    scramble_inputs();

    for (int i = 0; i < trace.size(); i++) begin
      check_eq($sformatf("bus[%0d]", i), 32'({cmd_mode, cmd_addr, cmd_data}), 32'(trace[i]));
      check_eq($sformatf("busy[%0d]", i), 32'(busy), 32'(1));
      check_eq($sformatf("valid[%0d]", i), 32'(result_valid), 32'(0));
      start = (i == glitch_at);
      if (rst_at_read && i == first_read) begin
        #2 rst_n = 1'b0;
        #1;
        exp_result = '0;
        check_idle("async_reset");
        @(negedge clk) rst_n = 1'b1;
        step();
        check_idle("after_reset");
        return;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        step();
        check_idle("abort_idle");
        return;
      end
      step();
    end
    start = 1'b0;

    for (int unsigned d = 0; d < rdy_delay; d++) begin
      check_eq("hold.valid", 32'(result_valid), 32'(1));
      check_eq("hold.result", 32'(result), 32'(rv[5:0]));
      check_eq("hold.busy", 32'(busy), 32'(1));
      check_eq("hold.bus", 32'({cmd_mode, cmd_addr, cmd_data}), 32'(BUS_NOP));
      step();
    end
    check_eq("hold.valid", 32'(result_valid), 32'(1));
    check_eq("hold.result", 32'(result), 32'(rv[5:0]));
    result_ready = hold_ready;
    abort        = hold_abort;
    step();
    result_ready = 1'b0;
    abort        = 1'b0;
    exp_result   = rv[5:0];
    check_idle("done");
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // Directed jobs.
    run_job(8'h02, 1'b1, 8'h01, 20, 8'h1B, 2, -1, -1, 1'b0, 1'b0, 1'b1);
    check_eq("result_27", 32'(result), 32'(27));
    run_job(8'h5A, 1'b0, 8'hA5, 0, 8'hF7, 0, -1, -1, 1'b0, 1'b0, 1'b1);
    run_job(8'h11, 1'b1, 8'h22, 1, 8'h2C, 10, -1, -1, 1'b0, 1'b0, 1'b1);
    run_job(8'h33, 1'b0, 8'h44, 5, 8'h15, 1, 3 + 100, -1, 1'b0, 1'b0, 1'b1);
    run_job(8'h66, 1'b1, 8'h77, 2, 8'h3E, 1, -1, -1, 1'b0, 1'b0, 1'b1);
    run_job(8'h88, 1'b0, 8'h99, 3, 8'h07, 0, -1, 3 + 50, 1'b0, 1'b0, 1'b1);
    // Abort on the final READ edge must not capture.
    run_job(8'h12, 1'b1, 8'h34, 0, 8'h2A, 0, 4, -1, 1'b0, 1'b0, 1'b1);
    run_job(8'hAB, 1'b1, 8'hCD, 1, 8'h39, 1, -1, -1, 1'b1, 1'b0, 1'b1);
    run_job(8'h01, 1'b0, 8'h02, 1, 8'h21, 2, -1, -1, 1'b0, 1'b1, 1'b1);
    run_job(8'h03, 1'b1, 8'h04, 0, 8'h0D, 3, -1, -1, 1'b0, 1'b1, 1'b0);

    // start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");
    step();
    check_idle("start_abort2");

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int unsigned it;
      int          ab;
      it = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 + it * CELLS + READ_LAT - 1)) : -1;
      run_job(8'($urandom), 1'($urandom), 8'($urandom), it, 8'($urandom),
              $urandom_range(0, 4), ab, -1, 1'b0, 1'($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/heat_cmd_sequencer.md
HEAT_CMD_SEQUENCER -- requirements
Module: heat_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: CELLS, default 64, grid cells swept per solver iteration; ITER_W, default 8, width of the iteration count; READ_LAT, default 2, cycles READ is held before the response is sampled.
REQ-002 Ports SHALL be: clk in 1, system clock; rst_n in 1, reset, asynchronous active-low; start in 1, begin a job; abort in 1, cancel the job; alpha_cfg in 8, alpha code; src_en in 1, centre heat-source enable; init_pat in 8, initial pattern select; iter_count in ITER_W, iterations to run; cmd_mode out 2, solver ui_in[7:6]; cmd_addr out 6, solver ui_in[5:0]; cmd_data out 8, solver uio_in; resp in 8, solver uo_out; busy out 1, job in progress; result out 6, max-temperature cell index; result_valid out 1, result available; result_ready in 1, consumer accepts the result.
REQ-003 The block SHALL run on one clock (clk) with asynchronous active-low reset rst_n; all outputs SHALL be registered.

Function
REQ-004 Command encodings SHALL be: cmd_mode 00 RUN, 01 NOP, 10 READ, 11 CONFIG; config addresses: 000000 ALPHA, 000101 SOURCE, 000111 INIT.
REQ-005 States SHALL be IDLE, CFG_ALPHA, CFG_SRC, CFG_INIT, RUN, READ, HOLD.
REQ-006 In IDLE, HOLD and after abort, the bus SHALL be NOP: mode 01, addr 0, data 0.
REQ-007 start sampled high in IDLE SHALL latch alpha_cfg, src_en, init_pat and iter_count, assert busy, and enter CFG_ALPHA on the next cycle; start outside IDLE SHALL be ignored.
REQ-008 CFG_ALPHA SHALL drive {11,000000,alpha} for exactly 1 cycle; CFG_SRC SHALL then drive {11,000101,{7'b0,src_en}} for 1 cycle; CFG_INIT SHALL then drive {11,000111,init_pat} for 1 cycle.
REQ-009 RUN SHALL drive {00,000000,0x00} for exactly iter_count*CELLS cycles, using a down-counter of ITER_W+log2(CELLS) bits with no overflow.
REQ-010 iter_count = 0 SHALL skip RUN and go from CFG_INIT directly to READ.
REQ-011 READ SHALL drive {10,000000,0x00} for READ_LAT cycles; resp[5:0] SHALL be captured on the final READ edge.
REQ-012 The cycle after capture SHALL enter HOLD with result_valid=1, result stable and busy=1.
REQ-013 In HOLD, result_valid && result_ready SHALL complete the transfer: next cycle result_valid=0, busy=0, state IDLE.
REQ-014 result SHALL keep its last captured value after the transfer until the next capture.
REQ-015 abort in any non-IDLE state SHALL force IDLE and NOP on the next cycle, with result_valid=0 and busy=0; result SHALL be unchanged.
REQ-016 If abort and result_ready are both high in HOLD, the transfer SHALL count as completed; the next state SHALL be IDLE either way.
REQ-017 start and abort high together in IDLE SHALL be ignored (abort wins).
REQ-018 From start sampled at edge N: CONFIG SHALL occupy N+1..N+3, RUN N+4..N+3+64*iter, READ the next READ_LAT cycles, and result_valid SHALL assert one cycle after the final READ cycle.

Reset
REQ-019 Reset SHALL set: state IDLE, cmd_mode 01, cmd_addr 0, cmd_data 0, busy 0, result 0, result_valid 0, all counters and latched parameters 0.
REQ-020 Reset asserted mid-job SHALL abandon the job immediately (asynchronous); after release the block SHALL be in IDLE and accept start.

Structure
REQ-021 The mode encodings, config addresses and state enum SHALL live in the shared package heat_cmd_pkg.
REQ-022 The block SHALL be a single module with no sub-modules; the RUN/READ counters SHALL be internal.

Verification
REQ-023 Bench: alpha=0x02, src=1, pat=0x01, iter=20, pulse start -> 3 CONFIG cycles with data 02/01/01, then exactly 1280 RUN cycles, 2 READ cycles; solver model drives resp=0x1B -> result=27, result_valid=1.
REQ-024 Bench: iter=0 -> CFG_INIT is followed immediately by READ with 0 RUN cycles; result_valid at N+6.
REQ-025 Bench: hold result_ready=0 for 10 cycles in HOLD -> result_valid and result stable, bus NOP; ready=1 -> valid drops the next cycle, busy=0.
REQ-026 Bench: abort at RUN cycle 100 -> next cycle NOP, busy=0, no result_valid; a new start then runs a full job.
REQ-027 Bench: start pulsed during RUN -> ignored, RUN length unchanged; rst_n low mid-READ -> outputs take reset values with no clock edge.
